// File: rtl/rst_seq_ctrl.sv
// Staged multi-domain reset sequencer: PLL lock + debounced button + per-domain software resets.
// Inputs reach the FSM 2 cycles after synchronisation; rst_no/all_released_o/rst_cause_o are registered.
module rst_seq_ctrl #(
    parameter int NumDomains     = 3,
    parameter int HoldCycles     = 256,
    parameter int StageGap       = 16,
    parameter int DebounceCycles = 1024,
    parameter int SwRstCycles    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pll_locked_i,
    input  logic                  rst_btn_i,
    input  logic [NumDomains-1:0] sw_rst_req_i,
    output logic [NumDomains-1:0] rst_no,
    output logic                  all_released_o,
    output logic [1:0]            rst_cause_o
);

    localparam int CntMax = (HoldCycles > StageGap) ? HoldCycles : StageGap;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam int DbW    = $clog2(DebounceCycles + 1);
    localparam int SwW    = $clog2(SwRstCycles + 1);
    localparam int StgW   = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    logic            lock_meta, lock_s;
    logic            btn_meta, btn_s, btn_db;
    logic [DbW-1:0]  db_cnt;

    state_t                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [StgW-1:0]         stage_q, stage_d;
    logic [NumDomains-1:0]   rst_d;
    logic [1:0]              cause_d;
    logic [SwW-1:0]          sw_cnt_q [NumDomains];
    logic [SwW-1:0]          sw_cnt_d [NumDomains];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            btn_meta  <= 1'b0;
            btn_s     <= 1'b0;
            btn_db    <= 1'b0;
            db_cnt    <= '0;
        end else begin
            lock_meta <= pll_locked_i;
            lock_s    <= lock_meta;
            btn_meta  <= rst_btn_i;
            btn_s     <= btn_meta;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DbW'(DebounceCycles - 1)) begin
                btn_db <= ~btn_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DbW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stage_d  = stage_q;
        rst_d    = rst_no;
        cause_d  = rst_cause_o;
        sw_cnt_d = sw_cnt_q;

        if (state_q == ST_ASSERT) begin
            rst_d = '0;
            cnt_d = '0;
            if (!btn_db) state_d = ST_WAIT_LOCK;
        end else if (!lock_s || btn_db) begin
            // Lock loss wins over the button; losing lock before ever having it keeps the old cause.
            state_d = ST_ASSERT;
            rst_d   = '0;
            cnt_d   = '0;
            stage_d = '0;
            for (int k = 0; k < NumDomains; k++) sw_cnt_d[k] = '0;
            if (!lock_s) begin
                if (state_q != ST_WAIT_LOCK) cause_d = 2'd1;
            end else begin
                cause_d = 2'd2;
            end
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
                ST_HOLD: begin
                    if (cnt_q == CntW'(HoldCycles - 1)) begin
                        rst_d[0] = 1'b1;
                        cnt_d    = '0;
                        stage_d  = StgW'(1);
                        state_d  = (NumDomains == 1) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CntW'(StageGap - 1)) begin
                        rst_d[stage_q] = 1'b1;
                        cnt_d          = '0;
                        stage_d        = stage_q + StgW'(1);
                        if (stage_q == StgW'(NumDomains - 1)) state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                ST_RUN: begin
                    for (int k = 0; k < NumDomains; k++) begin
                        if (sw_rst_req_i[k]) begin
                            sw_cnt_d[k] = SwW'(SwRstCycles);
                            rst_d[k]    = 1'b0;
                            cause_d     = 2'd3;
                        end else if (sw_cnt_q[k] != '0) begin
                            sw_cnt_d[k] = sw_cnt_q[k] - SwW'(1);
                            if (sw_cnt_q[k] == SwW'(1)) rst_d[k] = 1'b1;
                        end
                    end
                end
                default: state_d = ST_ASSERT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_ASSERT;
            cnt_q          <= '0;
            stage_q        <= '0;
            rst_no         <= '0;
            all_released_o <= 1'b0;
            rst_cause_o    <= 2'd0;
            for (int k = 0; k < NumDomains; k++) sw_cnt_q[k] <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stage_q        <= stage_d;
            rst_no         <= rst_d;
            all_released_o <= &rst_d;
            rst_cause_o    <= cause_d;
            for (int k = 0; k < NumDomains; k++) sw_cnt_q[k] <= sw_cnt_d[k];
        end
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl; edge n is the n-th rising edge after rst_i is released,
// and an input "changed at edge n" is driven 1 time unit after that edge.
module tb_rst_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       rst_btn = 1'b0;
    logic [2:0] sw_rst_req = 3'b000;
    logic [2:0] rst_no;
    logic       all_released;
    logic [1:0] rst_cause;

    int checks = 0;
    int errors = 0;
    int now_edge = 0;

    rst_seq_ctrl #(
        .NumDomains    (3),
        .HoldCycles    (8),
        .StageGap      (4),
        .DebounceCycles(5),
        .SwRstCycles   (6)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pll_locked_i  (pll_locked),
        .rst_btn_i     (rst_btn),
        .sw_rst_req_i  (sw_rst_req),
        .rst_no        (rst_no),
        .all_released_o(all_released),
        .rst_cause_o   (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic to_edge(input int n);
        repeat (n - now_edge) @(posedge clk);
        #1;
        now_edge = n;
    endtask

    task automatic check_out(input string tag, input logic [2:0] exp_rst,
                             input logic exp_all, input logic [1:0] exp_cause);
        check({tag, ".rst_no"}, 32'(rst_no), 32'(exp_rst));
        check({tag, ".all_released"}, 32'(all_released), 32'(exp_all));
        check({tag, ".cause"}, 32'(rst_cause), 32'(exp_cause));
    endtask

    // Holds rst for 3 edges, checks the reset state, then releases it with the PLL locked.
    task automatic do_reset(input string tag);
        rst        = 1'b1;
        rst_btn    = 1'b0;
        sw_rst_req = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check_out({tag, ".reset"}, 3'b000, 1'b0, 2'd0);
        rst        = 1'b0;
        pll_locked = 1'b1;
        now_edge   = -1;
    endtask

    initial begin
        // Power-up: HOLD entered at edge 3, releases at 11/15/19
        do_reset("s1");
        to_edge(10); check_out("s1.e10", 3'b000, 1'b0, 2'd0);
        to_edge(11); check_out("s1.e11", 3'b001, 1'b0, 2'd0);
        to_edge(14); check_out("s1.e14", 3'b001, 1'b0, 2'd0);
        to_edge(15); check_out("s1.e15", 3'b011, 1'b0, 2'd0);
        to_edge(18); check_out("s1.e18", 3'b011, 1'b0, 2'd0);
        to_edge(19); check_out("s1.e19", 3'b111, 1'b1, 2'd0);

        // Lock loss mid-release: drop at edge 16, fault lands at 19 and beats the last release
        do_reset("s2");
        to_edge(16); pll_locked = 1'b0;
        to_edge(18); check_out("s2.e18", 3'b011, 1'b0, 2'd0);
        to_edge(19); check_out("s2.e19", 3'b000, 1'b0, 2'd1);
        to_edge(29); check_out("s2.e29", 3'b000, 1'b0, 2'd1);
        to_edge(30); pll_locked = 1'b1;
        to_edge(40); check_out("s2.e40", 3'b000, 1'b0, 2'd1);
        to_edge(41); check_out("s2.e41", 3'b001, 1'b0, 2'd1);

        // Button: 4-cycle glitch ignored, 10-cycle press resets until btn_db clears
        do_reset("s3");
        to_edge(25); rst_btn = 1'b1;
        to_edge(29); rst_btn = 1'b0;
        to_edge(35); check_out("s3.glitch", 3'b111, 1'b1, 2'd0);
        to_edge(40); rst_btn = 1'b1;
        to_edge(47); check_out("s3.e47", 3'b111, 1'b1, 2'd0);
        to_edge(48); check_out("s3.e48", 3'b000, 1'b0, 2'd2);
        to_edge(50); rst_btn = 1'b0;
        to_edge(57); check_out("s3.e57", 3'b000, 1'b0, 2'd2);
        to_edge(66); check_out("s3.e66", 3'b000, 1'b0, 2'd2);
        to_edge(67); check_out("s3.e67", 3'b001, 1'b0, 2'd2);

        // Simultaneous: btn_db rises and lock_s falls after edge 32, both seen at 33
        do_reset("s4");
        to_edge(25); rst_btn = 1'b1;
        to_edge(30); pll_locked = 1'b0;
        to_edge(32); check_out("s4.e32", 3'b111, 1'b1, 2'd0);
        to_edge(33); check_out("s4.e33", 3'b000, 1'b0, 2'd1);

        // Software reset of domain 1, a restarted window, then two domains at once
        do_reset("s5");
        to_edge(20); sw_rst_req = 3'b010;
        to_edge(21); sw_rst_req = 3'b000;
        check_out("s5.e21", 3'b101, 1'b0, 2'd3);
        to_edge(26); check_out("s5.e26", 3'b101, 1'b0, 2'd3);
        to_edge(27); check_out("s5.e27", 3'b111, 1'b1, 2'd3);
        to_edge(30); sw_rst_req = 3'b010;
        to_edge(31); sw_rst_req = 3'b000;
        to_edge(33); sw_rst_req = 3'b010;
        to_edge(34); sw_rst_req = 3'b000;
        to_edge(37); check_out("s5.e37", 3'b101, 1'b0, 2'd3);
        to_edge(39); check_out("s5.e39", 3'b101, 1'b0, 2'd3);
        to_edge(40); check_out("s5.e40", 3'b111, 1'b1, 2'd3);
        to_edge(45); sw_rst_req = 3'b101;
        to_edge(46); sw_rst_req = 3'b000;
        check_out("s5.e46", 3'b010, 1'b0, 2'd3);
        to_edge(51); check_out("s5.e51", 3'b010, 1'b0, 2'd3);
        to_edge(52); check_out("s5.e52", 3'b111, 1'b1, 2'd3);

        // Software requests during HOLD have no effect on release timing
        do_reset("s6");
        to_edge(3);  sw_rst_req = 3'b111;
        to_edge(10); sw_rst_req = 3'b000;
        check_out("s6.e10", 3'b000, 1'b0, 2'd0);
        to_edge(11); check_out("s6.e11", 3'b001, 1'b0, 2'd0);
        to_edge(15); check_out("s6.e15", 3'b011, 1'b0, 2'd0);
        to_edge(19); check_out("s6.e19", 3'b111, 1'b1, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
